// File: rtl/contador_seq_pkg.sv
// contador_seq_pkg
//   Shared types and defaults for the Contador4B command sequencer.
//   op_t    : command opcodes carried on cmd_op
//   state_t : sequencer FSM states
package contador_seq_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int RW_DEF    = 4;
   localparam int STEPS_W   = 8;

   typedef enum logic [1:0] {
      OP_CLR    = 2'd0,
      OP_LOAD   = 2'd1,
      OP_COUNT  = 2'd2,
      OP_BOUNCE = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD   = 3'd2,
      S_RUN_UP = 3'd3,
      S_RUN_DN = 3'd4,
      S_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/contador4b.sv
// Contador4B
//   Up/down counter with synchronous clear and load. No reset of its own:
//   the sequencer clears it through run=0.
//   clock   : rising-edge clock
//   run     : 0 = clear to 0 (highest priority), 1 = operate
//   load    : load entrada (below clear, above count)
//   up_down : 1 = +1, 0 = -1, modulo 2^WIDTH
//   entrada : load data
//   valor   : registered counter value
module Contador4B #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             run,
   input  logic             load,
   input  logic             up_down,
   input  logic [WIDTH-1:0] entrada,
   output logic [WIDTH-1:0] valor
);

   always_ff @(posedge clock) begin
      if (!run)        valor <= '0;
      else if (load)   valor <= entrada;
      else if (up_down) valor <= valor + 1'b1;
      else             valor <= valor - 1'b1;
   end

endmodule

// File: rtl/contador_sequenciador.sv
// contador_sequenciador
//   Command-driven sequencer for one Contador4B. Commands (CLR, LOAD, COUNT,
//   BOUNCE) arrive on a valid/ready handshake; the block drives the counter
//   pins and watches cnt_valor. Between commands the counter is held by
//   reloading its own value (run=1, load=1, entrada=valor).
//   clock, reset            : clock; async active-high reset to IDLE
//   cmd_valid/cmd_ready     : command handshake (ready only in IDLE)
//   cmd_op/dir/value/reps   : opcode, COUNT direction, load value or target,
//                             BOUNCE round count (0 behaves as 1)
//   abort                   : ends the running command, counter keeps value
//   cnt_valor               : counter output
//   cnt_run/load/up_down/entrada : counter drive pins
//   busy, done              : state != IDLE; one-cycle completion pulse
//   Optional (macro CONTADOR_SEQ_STEP_EN): steps[7:0], saturating count of
//   counter steps taken by the current/last command.
module contador_sequenciador
   import contador_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int RW    = RW_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_value,
   input  logic [RW-1:0]    cmd_reps,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_valor,
   output logic             cnt_run,
   output logic             cnt_load,
   output logic             cnt_up_down,
   output logic [WIDTH-1:0] cnt_entrada,
   output logic             busy,
   output logic             done
`ifdef CONTADOR_SEQ_STEP_EN
   ,
   output logic [STEPS_W-1:0] steps
`endif
);

   state_t            state, state_nxt;
   op_t               op_q;
   logic              dir_q;
   logic [WIDTH-1:0]  value_q, start_q;
   logic [RW-1:0]     reps_q;
   logic              accept;
   logic              step_drv;   // a count drive is issued this cycle
   logic              reps_dec;   // one BOUNCE round finished
   logic [WIDTH-1:0]  dn_target;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   // RUN_DN heads for the start point when bouncing, else for the target
   assign dn_target = (op_q == OP_BOUNCE) ? start_q : value_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         op_q    <= OP_CLR;
         dir_q   <= 1'b1;
         value_q <= '0;
         start_q <= '0;
         reps_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= op_t'(cmd_op);
            dir_q   <= cmd_dir;
            value_q <= cmd_value;
            start_q <= cnt_valor;
            reps_q  <= (cmd_reps == '0) ? RW'(1) : cmd_reps;
         end else if (reps_dec) begin
            reps_q <= reps_q - 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_run     = 1'b1;
      cnt_load    = 1'b1;
      cnt_up_down = dir_q;
      cnt_entrada = cnt_valor;
      step_drv    = 1'b0;
      reps_dec    = 1'b0;
      done        = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept) begin
               case (op_t'(cmd_op))
                  OP_CLR:   state_nxt = S_CLEAR;
                  OP_LOAD:  state_nxt = S_LOAD;
                  OP_COUNT: state_nxt = cmd_dir ? S_RUN_UP : S_RUN_DN;
                  default:  state_nxt = S_RUN_UP;
               endcase
            end
         end
         S_CLEAR: begin
            cnt_run   = 1'b0;
            state_nxt = S_DONE;
         end
         S_LOAD: begin
            cnt_entrada = value_q;
            state_nxt   = S_DONE;
         end
         S_RUN_UP: begin
            if (cnt_valor != value_q) begin
               cnt_load    = 1'b0;
               cnt_up_down = 1'b1;
               step_drv    = 1'b1;
            end else if (op_q == OP_BOUNCE && value_q != start_q) begin
               state_nxt = S_RUN_DN;
            end else begin
               // COUNT reached, or a degenerate bounce with nowhere to go
               state_nxt = S_DONE;
            end
         end
         S_RUN_DN: begin
            if (cnt_valor != dn_target) begin
               cnt_load    = 1'b0;
               cnt_up_down = 1'b0;
               step_drv    = 1'b1;
            end else if (op_q == OP_BOUNCE) begin
               reps_dec  = 1'b1;
               state_nxt = (reps_q <= RW'(1)) ? S_DONE : S_RUN_UP;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      // abort wins over whatever the state wanted: hold the counter and finish
      if (abort && (state == S_CLEAR || state == S_LOAD ||
                    state == S_RUN_UP || state == S_RUN_DN)) begin
         state_nxt   = S_DONE;
         cnt_run     = 1'b1;
         cnt_load    = 1'b1;
         cnt_entrada = cnt_valor;
         step_drv    = 1'b0;
         reps_dec    = 1'b0;
      end
   end

`ifdef CONTADOR_SEQ_STEP_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                   steps <= '0;
      else if (accept)                             steps <= '0;
      else if (step_drv && steps != {STEPS_W{1'b1}}) steps <= steps + 1'b1;
   end
`endif

endmodule

// File: tb/tb_contador_sequenciador.sv
module tb_contador_sequenciador;
   import contador_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic       cmd_dir = 1'b0;
   logic [3:0] cmd_value = 4'd0;
   logic [3:0] cmd_reps = 4'd0;
   logic       abort = 1'b0;
   logic [3:0] cnt_valor;
   logic       cnt_run, cnt_load, cnt_up_down;
   logic [3:0] cnt_entrada;
   logic       busy, done;
`ifdef CONTADOR_SEQ_STEP_EN
   logic [7:0] steps;
`endif

   contador_sequenciador #(.WIDTH(4), .RW(4)) dut (
      .clock(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dir(cmd_dir), .cmd_value(cmd_value), .cmd_reps(cmd_reps),
      .abort(abort), .cnt_valor(cnt_valor),
      .cnt_run(cnt_run), .cnt_load(cnt_load), .cnt_up_down(cnt_up_down),
      .cnt_entrada(cnt_entrada), .busy(busy), .done(done)
`ifdef CONTADOR_SEQ_STEP_EN
      , .steps(steps)
`endif
   );

   Contador4B #(.WIDTH(4)) u_cnt (
      .clock(clk), .run(cnt_run), .load(cnt_load), .up_down(cnt_up_down),
      .entrada(cnt_entrada), .valor(cnt_valor)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      int         lat;
   } done_t;

   logic [3:0] trace_q[$];
   done_t      done_q[$];
   int         checks = 0;
   int         errors = 0;
   bit         trace_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the trace queue on every counter change and the done
   // queue on every done pulse; latency is measured from the accept cycle.
   int         cyc = 0;
   int         acc_cyc = 0;
   logic [3:0] prev = 4'd0;
   always @(negedge clk) begin
      done_t e;
      logic [3:0] t;
      cyc++;
      if (cmd_valid && cmd_ready && !reset) acc_cyc = cyc;
      if (trace_en && cnt_valor != prev) begin
         if (trace_q.size() == 0) chk("unexpected_step", int'(cnt_valor), -1);
         else begin
            t = trace_q.pop_front();
            chk("trace", int'(cnt_valor), int'(t));
         end
      end
      prev = cnt_valor;
      if (done) begin
         if (done_q.size() == 0) chk("unexpected_done", int'(cnt_valor), -1);
         else begin
            e = done_q.pop_front();
            chk("done_valor", int'(cnt_valor), int'(e.v));
            chk("done_latency", cyc - acc_cyc, e.lat);
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic dir,
                        input logic [3:0] val, input logic [3:0] reps);
      int n = 0;
      @(posedge clk); #1;
      cmd_op = op; cmd_dir = dir; cmd_value = val; cmd_reps = reps;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n == 100) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         n++;
      end
      if (!seen) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic push_done(input logic [3:0] v, input int lat);
      done_t e;
      e.v = v; e.lat = lat;
      done_q.push_back(e);
   endtask

   task automatic push_trace(input logic [3:0] v);
      trace_q.push_back(v);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_run", int'(cnt_run), 1);
      chk("rst_load", int'(cnt_load), 1);
      chk("rst_entrada", int'(cnt_entrada), int'(cnt_valor));
      @(posedge clk); #1 reset = 1'b0;

      // bring counter to a known 0
      push_done(4'd0, 2);
      issue(2'd0, 1'b0, 4'd0, 4'd0);
      wait_done();
      chk("clr_init", int'(cnt_valor), 0);
      trace_en = 1'b1;

      // 1: LOAD 10
      push_trace(4'd10); push_done(4'd10, 2);
      issue(2'd1, 1'b0, 4'd10, 4'd0);
      wait_done();
      chk("load_idle_ready", int'(cmd_ready), 1);

      // 2: COUNT up to 13, then idle
      push_trace(4'd11); push_trace(4'd12); push_trace(4'd13);
      push_done(4'd13, 5);
      issue(2'd2, 1'b1, 4'd13, 4'd0);
      wait_done();
      repeat (6) @(posedge clk);
      #1 chk("hold_13", int'(cnt_valor), 13);
`ifdef CONTADOR_SEQ_STEP_EN
      chk("steps_count3", int'(steps), 3);
`endif

      // 3: LOAD 14, COUNT up to 2 with wrap
      push_trace(4'd14); push_done(4'd14, 2);
      issue(2'd1, 1'b0, 4'd14, 4'd0);
      wait_done();
      push_trace(4'd15); push_trace(4'd0); push_trace(4'd1); push_trace(4'd2);
      push_done(4'd2, 6);
      issue(2'd2, 1'b1, 4'd2, 4'd0);
      wait_done();
`ifdef CONTADOR_SEQ_STEP_EN
      chk("steps_wrap4", int'(steps), 4);
`endif

      // 4: BOUNCE 12 reps 2 from 10, then reps 0 (one round)
      push_trace(4'd10); push_done(4'd10, 2);
      issue(2'd1, 1'b0, 4'd10, 4'd0);
      wait_done();
      for (int r = 0; r < 2; r++) begin
         push_trace(4'd11); push_trace(4'd12); push_trace(4'd11); push_trace(4'd10);
      end
      push_done(4'd10, 13);
      issue(2'd3, 1'b0, 4'd12, 4'd2);
      wait_done();
      push_trace(4'd11); push_trace(4'd12); push_trace(4'd11); push_trace(4'd10);
      push_done(4'd10, 7);
      issue(2'd3, 1'b0, 4'd12, 4'd0);
      wait_done();
      // degenerate cases: bounce to own value, count with zero distance
      push_done(4'd10, 2);
      issue(2'd3, 1'b0, 4'd10, 4'd3);
      wait_done();
      push_done(4'd10, 2);
      issue(2'd2, 1'b1, 4'd10, 4'd0);
      wait_done();

      // 5: LOAD 9, COUNT down to 3 aborted at third RUN cycle
      push_trace(4'd9); push_done(4'd9, 2);
      issue(2'd1, 1'b0, 4'd9, 4'd0);
      wait_done();
      push_trace(4'd8); push_trace(4'd7); push_done(4'd7, 4);
      issue(2'd2, 1'b0, 4'd3, 4'd0);
      @(posedge clk); @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      wait_done();
      repeat (3) @(posedge clk);
      #1 chk("abort_hold_7", int'(cnt_valor), 7);
      push_trace(4'd6); push_trace(4'd5); push_done(4'd5, 4);
      issue(2'd2, 1'b0, 4'd5, 4'd0);
      wait_done();

      // 6: reset in the middle of a BOUNCE from 5 toward 8
      push_trace(4'd6); push_trace(4'd7);
      issue(2'd3, 1'b0, 4'd8, 4'd1);
      @(posedge clk); @(posedge clk); #1 reset = 1'b1;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ready", int'(cmd_ready), 1);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_run", int'(cnt_run), 1);
      chk("mid_rst_load", int'(cnt_load), 1);
      chk("mid_rst_entrada", int'(cnt_entrada), int'(cnt_valor));
      chk("mid_rst_valor", int'(cnt_valor), 7);
`ifdef CONTADOR_SEQ_STEP_EN
      chk("mid_rst_steps", int'(steps), 0);
`endif
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("post_rst_valor", int'(cnt_valor), 7);
      push_trace(4'd0); push_done(4'd0, 2);
      issue(2'd0, 1'b0, 4'd0, 4'd0);
      wait_done();

      repeat (3) @(posedge clk);
      chk("trace_q_empty", trace_q.size(), 0);
      chk("done_q_empty", done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
